// File: rtl/sci_frame_rx_pkg.sv
// Shared constants for the SCI frame receiver: NN input sizing, start byte,
// error codes and parser state encodings.
package sci_frame_rx_pkg;

  localparam int I_NUM = 64;
  localparam int D_LEN = 8;

  function automatic int bytes_of(input int nbits);
    return (nbits + 7) / 8;
  endfunction

  localparam int I_BYTES = bytes_of(I_NUM);

  localparam logic [7:0] SOF_BYTE = 8'hAA;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_LINE    = 3'd4;
  localparam logic [2:0] ERR_BUSY    = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEN  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

endpackage

// File: rtl/sci_byte_sync.sv
// Two-flop synchronizer for an asynchronous level followed by a registered
// rising-edge detector producing a single-cycle strobe.
module sci_byte_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic stb_o
);

  logic [2:0] sh_q;
  logic       stb_q;

  // Synchronizer chain; sh_q[2] is the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= 3'b000;
      stb_q <= 1'b0;
    end else begin
      sh_q  <= {sh_q[1:0], sig_i};
      stb_q <= sh_q[1] & ~sh_q[2];
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/sci_frame_rx.sv
// Frame parser between the UART receiver and the NN core input register:
// SOF / LEN / payload / CSUM with inter-byte timeout and error reporting.
module sci_frame_rx
  import sci_frame_rx_pkg::*;
#(
  parameter int         I_NUM       = sci_frame_rx_pkg::I_NUM,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SOF         = SOF_BYTE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rx_error,
  input  logic             nn_finish,
  output logic [I_NUM-1:0] a_in,
  output logic             nn_start,
  output logic             busy,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [7:0]       err_cnt
);

  localparam int             NBYTES   = bytes_of(I_NUM);
  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     LEN_OK   = 8'(NBYTES);
  localparam logic [7:0]     IDX_LAST = 8'(NBYTES - 1);

  logic byte_stb;
  logic err_stb;

  sci_byte_sync u_sync_ready (.clk(clk), .rst_n(rst_n), .sig_i(rx_ready), .stb_o(byte_stb));
  sci_byte_sync u_sync_error (.clk(clk), .rst_n(rst_n), .sig_i(rx_error), .stb_o(err_stb));

  logic [1:0]          state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          sum_q, sum_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NBYTES*8-1:0] shadow_q, shadow_d;
  logic [I_NUM-1:0]    a_in_q, a_in_d;
  logic                nn_start_q, nn_start_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic [2:0]          err_code_q, err_code_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                raise;
  logic [2:0]          code;
  logic                busy_eff;

  // Parser next state; nn_finish is folded into busy before the CSUM decision.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    shadow_d   = shadow_q;
    a_in_d     = a_in_q;
    nn_start_d = 1'b0;
    raise      = 1'b0;
    code       = ERR_NONE;
    busy_eff   = busy_q & ~nn_finish;
    busy_d     = busy_eff;
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (err_stb) begin
      raise   = 1'b1;
      code    = ERR_LINE;
      state_d = ST_IDLE;
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
      raise   = 1'b1;
      code    = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end else if (byte_stb) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SOF) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (rx_data == LEN_OK) begin
            shadow_d = '0;
            idx_d    = 8'd0;
            sum_d    = rx_data;
            state_d  = ST_PAY;
          end else begin
            raise   = 1'b1;
            code    = ERR_BAD_LEN;
            state_d = ST_IDLE;
          end
        end
        ST_PAY: begin
          shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
          sum_d = sum_q + rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAY;
          end
        end
        ST_CSUM: begin
          if ((sum_q + rx_data) != 8'd0) begin
            raise = 1'b1;
            code  = ERR_CSUM;
          end else if (busy_eff) begin
            raise = 1'b1;
            code  = ERR_BUSY;
          end else begin
            a_in_d     = shadow_q[I_NUM-1:0];
            nn_start_d = 1'b1;
            busy_d     = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    frame_err_d = raise;
    if (raise) begin
      err_code_d = code;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end else begin
      err_code_d = err_code_q;
      err_cnt_d  = err_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      a_in_q      <= '0;
      nn_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      a_in_q      <= a_in_d;
      nn_start_q  <= nn_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign a_in      = a_in_q;
  assign nn_start  = nn_start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;

endmodule
